mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single RCPU memory port (`memAddr`/`memWrite`/`memWE`/`memRead`) between the CPU core (port 0) and a second bus master such as a DMA or debug loader (port 1). Each cycle it grants at most one single-word access, using round-robin arbitration with a bounded burst length. It registers the winning request onto the memory bus and returns read data with a one-cycle valid strobe. It sits between `rcpu` and the memory model at the top level.

## Interface
- `M`, 16, data and address width.
- `MAX_BURST`, 4, maximum consecutive grants to one port while the other port is requesting. Legal range 1..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high. Clears all state on the clock edge while asserted.
- `req0`, `req1`  in  1  access request for port 0 (CPU) and port 1.
- `we0`, `we1`  in  1  write request (1) or read request (0); sampled with `req`.
- `addr0`, `addr1`  in  M  word address.
- `wdata0`, `wdata1`  in  M  write data.
- `lock0`, `lock1`  in  1  hold ownership; effective only with `MEM_ARB_LOCK_EN`.
- `gnt0`, `gnt1`  out  1  combinational accept. `req & gnt` at a rising edge means the access is taken. The two grants are mutually exclusive.
- `rdata`  out  M  read data, combinational pass-through of `memRead`.
- `rvalid0`, `rvalid1`  out  1  registered; `rdata` is valid for the port whose strobe is high.
- `memAddr`  out  M  registered memory address.
- `memWrite`  out  M  registered memory write data.
- `memWE`  out  1  registered write enable, a one-cycle pulse per accepted write.
- `memRead`  in  M  memory read data; combinational on `memAddr`.

## Operation
- **States:** IDLE, OWN0, OWN1. There is a burst counter `cnt` of 4 bits, saturating at `MAX_BURST`.
- **Reset values:** state IDLE, `cnt`=0, `memAddr`=0, `memWrite`=0, `memWE`=0, `rvalid0`=`rvalid1`=0. `gnt0`/`gnt1` are 0 while `rst` is high.
- **IDLE:**
  - `req0` alone or both requesting: grant port 0, go to OWN0, `cnt`=1. Port 0 wins ties out of IDLE.
  - `req1` alone: grant port 1, go to OWN1, `cnt`=1.
  - No request: stay in IDLE.
- **OWNx, port x keeps the grant** when `req_x` is high and any of these holds: `cnt`<`MAX_BURST`, other port idle, or lock active. Then `cnt` = min(`cnt`+1, `MAX_BURST`).
- **OWNx, switch to port y** when `req_y` is high and port x does not keep the grant. Grant port y, go to OWNy, `cnt`=1.
- **OWNx, no requests:** go to IDLE, `cnt`=0.
- **On an accepted access:** the next edge loads `memAddr`←addr, `memWrite`←wdata and `memWE`←we.
- **Without an accept:** `memAddr` and `memWrite` hold their values and `memWE`=0.
- **Read accept:** sets the matching `rvalid` for exactly the next cycle. A write accept sets no `rvalid`.
- **Request hold:** a requester holds `req`, `we`, `addr` and `wdata` stable until it sees a grant. The arbiter never drops a pending request.

## Timing
- **Cycle t:** `req`/`gnt` are evaluated; the accept happens at the edge ending cycle t.
- **Cycle t+1:** the memory bus carries the access. For a read, `rdata`=`memRead` and `rvalidN`=1 in this cycle. Read latency is 1 cycle.
- **Throughput:** one access per cycle, back-to-back, with no bubbles when switching owners.
- **Starvation bound:** a continuously requesting port waits at most `MAX_BURST` cycles when lock is not used.
- **Reset mid-operation:** `rst` asserted in cycle t+1 of an accepted write still drives `memWE` in that cycle; `memWE` is 0 from the following cycle. Pending `rvalid` is cleared at the reset edge.

## Configuration
- **`MEM_ARB_LOCK_EN` defined:**
  - `lockx` is honoured only while the arbiter is in OWNx and `req_x` is high.
  - Ownership is then kept regardless of `cnt`, with `cnt` still saturating.
  - A lock asserted by the non-owner has no effect.
  - Dropping `req_x` ends the lock.
- **Not defined:** `lock0`/`lock1` ports remain but are ignored, and the burst cap always applies.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req0`=`req1`=1 → `gnt`=0, `memWE`=0, `memAddr`=0, `rvalid`=0. First grant goes to port 0 on the cycle after reset is released.
- **Single read:** port 0 reads `addr0`=0x0010 with memory[0x0010]=0xBEEF → `memAddr`=0x0010 next cycle, `rdata`=0xBEEF with `rvalid0`=1 for exactly one cycle.
- **Single write:** port 1 writes 0x1234 to 0x0100 → one-cycle `memWE` pulse, `memAddr`=0x0100, `memWrite`=0x1234, no `rvalid`.
- **Burst cap:** both ports request continuously with `MAX_BURST`=4 → grant pattern 0,0,0,0,1,1,1,1,0…, with no idle cycle on the memory bus.
- **Lock (with `MEM_ARB_LOCK_EN`):** port 1 owns with `lock1`=1 while `req0`=1 → port 1 is granted for 10 consecutive cycles. Dropping `req1` hands the grant to port 0 on the next cycle. Without the macro, port 0 is granted after 4 cycles.
- **Mid-burst reset:** `rst` pulsed during a burst → state returns to IDLE and no stale `rvalid` appears afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two masters, with a per-owner burst cap.
// Define MEM_ARB_LOCK_EN to let the current owner hold the port via lock0/lock1.
module mem_arbiter #(
   parameter int M         = 16,
   parameter int MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic [M-1:0] addr0,
   input  logic [M-1:0] addr1,
   input  logic [M-1:0] wdata0,
   input  logic [M-1:0] wdata1,
   input  logic         lock0,
   input  logic         lock1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [M-1:0] rdata,
   output logic         rvalid0,
   output logic         rvalid1,
   output logic [M-1:0] memAddr,
   output logic [M-1:0] memWrite,
   output logic         memWE,
   input  logic [M-1:0] memRead
);
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] CAP = 4'(MAX_BURST);

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [M-1:0] mem_addr_q, mem_addr_d;
   logic [M-1:0] mem_write_q, mem_write_d;
   logic         mem_we_q, mem_we_d;
   logic         rvalid0_q, rvalid0_d;
   logic         rvalid1_q, rvalid1_d;
   logic         lock0_eff, lock1_eff;
   logic         keep0, keep1;
   logic         g0, g1;

`ifdef MEM_ARB_LOCK_EN
   assign lock0_eff = lock0;
   assign lock1_eff = lock1;
`else
   logic unused_lock;
   assign unused_lock = lock0 ^ lock1;
   assign lock0_eff   = 1'b0;
   assign lock1_eff   = 1'b0;
`endif

   // The owner keeps the port while under the cap, uncontested, or locked.
   assign keep0 = req0 && ((cnt_q < CAP) || !req1 || lock0_eff);
   assign keep1 = req1 && ((cnt_q < CAP) || !req0 || lock1_eff);

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      case (state_q)
         IDLE: begin
            g0 = req0;
            g1 = req1 && !req0;
         end
         OWN0: begin
            g0 = keep0;
            g1 = req1 && !keep0;
         end
         OWN1: begin
            g1 = keep1;
            g0 = req0 && !keep1;
         end
         default: ;
      endcase
      if (rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   always_comb begin
      state_d     = IDLE;
      cnt_d       = '0;
      mem_addr_d  = mem_addr_q;
      mem_write_d = mem_write_q;
      mem_we_d    = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      if (g0) begin
         state_d     = OWN0;
         cnt_d       = (state_q == OWN0) ? ((cnt_q < CAP) ? cnt_q + 4'd1 : CAP) : 4'd1;
         mem_addr_d  = addr0;
         mem_write_d = wdata0;
         mem_we_d    = we0;
         rvalid0_d   = !we0;
      end else if (g1) begin
         state_d     = OWN1;
         cnt_d       = (state_q == OWN1) ? ((cnt_q < CAP) ? cnt_q + 4'd1 : CAP) : 4'd1;
         mem_addr_d  = addr1;
         mem_write_d = wdata1;
         mem_we_d    = we1;
         rvalid1_d   = !we1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_addr_q  <= '0;
         mem_write_q <= '0;
         mem_we_q    <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_write_q <= mem_write_d;
         mem_we_q    <= mem_we_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
      end
   end

   assign gnt0     = g0;
   assign gnt1     = g1;
   assign rdata    = memRead;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign memAddr  = mem_addr_q;
   assign memWrite = mem_write_q;
   assign memWE    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level ownership model and reference memory.
module tb_mem_arbiter;
   localparam int M    = 16;
   localparam int MAXB = 4;
`ifdef MEM_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, req0, req1, we0, we1, lock0, lock1;
   logic [M-1:0] addr0, addr1, wdata0, wdata1;
   logic         gnt0, gnt1, rvalid0, rvalid1, memWE;
   logic [M-1:0] rdata, memAddr, memWrite, memRead;

   logic [M-1:0] mem     [256];
   logic [M-1:0] ref_mem [256];
   assign memRead = mem[memAddr[7:0]];

   mem_arbiter #(.M(M), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .lock0(lock0), .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .memAddr(memAddr), .memWrite(memWrite), .memWE(memWE), .memRead(memRead)
   );

   int n_pass = 0, n_total = 0;
   // Model: current owner (-1 none), consecutive grants held, last winner.
   int owner = -1, run = 0, win = -1, last_win = -1;
   logic         exp_we = 0, exp_rv0 = 0, exp_rv1 = 0;
   logic [M-1:0] exp_addr = 0, exp_wdata = 0;
   logic         obs_g0, obs_g1, obs_we, obs_rv0, obs_rv1;
   logic [M-1:0] obs_rdata, obs_addr, obs_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int pick();
      logic [1:0] rq;
      logic [1:0] lk;
      int oth;
      rq = {req1, req0};
      lk = {lock1, lock0};
      if (rst || rq == 2'b00) return -1;
      if (owner < 0) return rq[0] ? 0 : 1;
      oth = 1 - owner;
      if (!rq[owner]) return oth;
      if (!rq[oth] || run < MAXB || (LOCK_EN && lk[owner])) return owner;
      return oth;
   endfunction

   task automatic cycle();
      @(negedge clk);
      win = pick();
      obs_g0 = gnt0;  obs_g1 = gnt1;  obs_we = memWE;  obs_addr = memAddr;
      obs_wdata = memWrite;  obs_rv0 = rvalid0;  obs_rv1 = rvalid1;  obs_rdata = rdata;
      chk("gnt0", 32'(gnt0), 32'(win == 0));
      chk("gnt1", 32'(gnt1), 32'(win == 1));
      chk("memWE", 32'(memWE), 32'(exp_we));
      chk("memAddr", 32'(memAddr), 32'(exp_addr));
      chk("memWrite", 32'(memWrite), 32'(exp_wdata));
      chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
      chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
      if (exp_rv0 || exp_rv1) chk("rdata", 32'(rdata), 32'(ref_mem[exp_addr[7:0]]));
      if (memWE) mem[memAddr[7:0]] = memWrite;
      @(posedge clk);
      exp_we = 1'b0;  exp_rv0 = 1'b0;  exp_rv1 = 1'b0;
      if (rst) begin
         owner = -1;  run = 0;  exp_addr = '0;  exp_wdata = '0;
      end else if (win >= 0) begin
         if (win == owner) run = (run < MAXB) ? run + 1 : MAXB;
         else begin owner = win;  run = 1;  end
         exp_addr  = (win == 0) ? addr0 : addr1;
         exp_wdata = (win == 0) ? wdata0 : wdata1;
         exp_we    = (win == 0) ? we0 : we1;
         exp_rv0   = (win == 0) && !we0;
         exp_rv1   = (win == 1) && !we1;
         if (exp_we) ref_mem[exp_addr[7:0]] = exp_wdata;
      end else begin
         owner = -1;  run = 0;
      end
      last_win = win;
      #1;
   endtask

   task automatic go_idle();
      req0 = 0;  req1 = 0;  lock0 = 0;  lock1 = 0;
      cycle();
   endtask

   initial begin
      int run1;
      bit stop;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h10] = 16'hBEEF;  ref_mem[8'h10] = 16'hBEEF;

      // Reset held with both ports requesting reads.
      rst = 1;  req0 = 1;  req1 = 1;  we0 = 0;  we1 = 0;  lock0 = 0;  lock1 = 0;
      addr0 = 16'h0020;  addr1 = 16'h0030;  wdata0 = 0;  wdata1 = 0;
      @(posedge clk);  #1;
      cycle();  cycle();
      chk("rst_gnt", 32'({obs_g1, obs_g0}), 32'd0);
      rst = 0;
      cycle();
      chk("rst_first_gnt0", 32'(obs_g0), 32'd1);
      go_idle();  go_idle();

      // Single read by port 0.
      req0 = 1;  we0 = 0;  addr0 = 16'h0010;
      cycle();
      req0 = 0;
      cycle();
      chk("rd_addr", 32'(obs_addr), 32'h0010);
      chk("rd_data", 32'(obs_rdata), 32'hBEEF);
      chk("rd_rv0", 32'(obs_rv0), 32'd1);
      cycle();
      chk("rd_rv0_once", 32'(obs_rv0), 32'd0);

      // Single write by port 1.
      req1 = 1;  we1 = 1;  addr1 = 16'h0100;  wdata1 = 16'h1234;
      cycle();
      req1 = 0;
      cycle();
      chk("wr_we", 32'(obs_we), 32'd1);
      chk("wr_addr", 32'(obs_addr), 32'h0100);
      chk("wr_data", 32'(obs_wdata), 32'h1234);
      chk("wr_no_rv", 32'({obs_rv1, obs_rv0}), 32'd0);
      cycle();
      chk("wr_pulse", 32'(obs_we), 32'd0);

      // Burst cap: both ports continuously reading from IDLE.
      go_idle();
      req0 = 1;  req1 = 1;  we0 = 0;  we1 = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         chk("burst_pattern", 32'({obs_g1, obs_g0}), ((i / MAXB) % 2 == 0) ? 32'd1 : 32'd2);
      end

      // Lock: port 1 owns, then port 0 joins while lock1 is held.
      go_idle();
      req1 = 1;  lock1 = 1;
      cycle();
      req0 = 1;
      run1 = 0;  stop = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (obs_g1 && !stop) run1++;
         else stop = 1;
      end
      chk("lock_run", 32'(run1), LOCK_EN ? 32'd10 : 32'(MAXB - 1));
      req1 = 0;  lock1 = 0;
      cycle();
      chk("lock_handoff", 32'(obs_g0), 32'd1);

      // Reset pulsed in the middle of a read burst.
      go_idle();
      req0 = 1;  req1 = 1;  we0 = 0;  we1 = 0;
      cycle();  cycle();
      rst = 1;
      cycle();
      rst = 0;  req0 = 0;  req1 = 0;
      cycle();
      chk("rst_no_rv", 32'({obs_rv1, obs_rv0}), 32'd0);
      cycle();

      // Random traffic: requesters hold their request until granted.
      for (int c = 0; c < 3000; c++) begin
         if (!req0 || last_win == 0) begin
            req0 = ($urandom_range(0, 3) != 0);  we0 = 1'($urandom_range(0, 1));
            addr0 = 16'($urandom);  wdata0 = 16'($urandom);
         end
         if (!req1 || last_win == 1) begin
            req1 = ($urandom_range(0, 3) != 0);  we1 = 1'($urandom_range(0, 1));
            addr1 = 16'($urandom);  wdata1 = 16'($urandom);
         end
         lock0 = ($urandom_range(0, 3) == 0);
         lock1 = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 0;
      go_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
